// File: rtl/muldiv_sequencer_if.sv
// Issue/control bundle between ID/EX and the mul/div sequencer.
// master: start, op_funct, abort out; ctrl, busy, done, stall, step in.
interface muldiv_sequencer_if #(
   parameter int FUNC_W = 6,
   parameter int CW     = 5
);
   logic              start;
   logic [FUNC_W-1:0] op_funct;
   logic              abort;
   logic [FUNC_W-1:0] ctrl;
   logic              busy;
   logic              done;
   logic              stall;
   logic [CW-1:0]     step;

   modport master (
      output start, op_funct, abort,
      input  ctrl, busy, done, stall, step
   );

   modport slave (
      input  start, op_funct, abort,
      output ctrl, busy, done, stall, step
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage.
// Ports: clk, rst_n (sync, active-low), bus (slave: issue in, control out).
module muldiv_sequencer #(
   parameter int                CYCLES    = 32,
   parameter int                FUNC_W    = 6,
   parameter logic [FUNC_W-1:0] DONE_CODE = {FUNC_W{1'b1}},
   parameter logic [FUNC_W-1:0] IDLE_CODE = '0,
   localparam int               CW        = $clog2(CYCLES)
) (
   input logic               clk,
   input logic               rst_n,
   muldiv_sequencer_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t            state, state_d;
   logic [FUNC_W-1:0] funct_q, funct_d;
   logic [FUNC_W-1:0] ctrl_q, ctrl_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [CW-1:0]     step_q, step_d;

   logic valid_op;
   logic accept;
   logic last;

   assign valid_op = (bus.op_funct == FUNC_W'(24)) |
                     (bus.op_funct == FUNC_W'(25)) |
                     (bus.op_funct == FUNC_W'(26)) |
                     (bus.op_funct == FUNC_W'(27));

   // Reset masks the issue so a held start never freezes the pipe.
   assign accept = rst_n & bus.start & valid_op &
                   (state != S_RUN) & ~bus.abort;

   assign last = (step_q == CW'(CYCLES - 1));

   assign bus.stall = accept |
                      (rst_n & (state == S_RUN) & ~bus.abort);

   always_comb begin
      state_d = state;
      funct_d = funct_q;
      ctrl_d  = IDLE_CODE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      step_d  = '0;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (accept) begin
               state_d = S_RUN;
               funct_d = bus.op_funct;
               ctrl_d  = bus.op_funct;
               busy_d  = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (last) begin
               state_d = S_DONE;
               ctrl_d  = DONE_CODE;
               done_d  = 1'b1;
            end else begin
               step_d = step_q + CW'(1);
               ctrl_d = funct_q;
               busy_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         funct_q <= IDLE_CODE;
         ctrl_q  <= IDLE_CODE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         step_q  <= '0;
      end else begin
         state   <= state_d;
         funct_q <= funct_d;
         ctrl_q  <= ctrl_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         step_q  <= step_d;
      end
   end

   assign bus.ctrl = ctrl_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.step = step_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomised and directed bench for muldiv_sequencer.
// Reference model is a timeline: outputs follow from cycles since issue.
module tb_muldiv_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   muldiv_sequencer_if #(.FUNC_W(6), .CW(5)) b32 ();
   muldiv_sequencer_if #(.FUNC_W(6), .CW(1)) b2 ();
   muldiv_sequencer_if #(.FUNC_W(6), .CW(6)) b64 ();

   muldiv_sequencer #(.CYCLES(32)) u32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b32)
   );
   muldiv_sequencer #(.CYCLES(2)) u2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b2)
   );
   muldiv_sequencer #(.CYCLES(64)) u64 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b64)
   );

   int errs = 0;
   int checks = 0;

   // model: issue edge index, funct, and whether an op is alive
   int       cur = 0;
   int       m_at = 0;
   bit       m_active = 1'b0;
   bit       m_accept = 1'b0;
   bit       m_inrun = 1'b0;
   logic [5:0] m_f = '0;

   logic       e_stall;
   logic [5:0] e_ctrl;
   logic       e_busy;
   logic       e_done;
   logic [4:0] e_step;

   function automatic bit valid_f(input logic [5:0] f);
      return (f >= 6'd24) && (f <= 6'd27);
   endfunction

   task automatic drive(input bit r, input bit s,
                        input logic [5:0] f, input bit a);
      int d;
      @(negedge clk);
      rst_n        = r;
      b32.start    = s;
      b32.op_funct = f;
      b32.abort    = a;
      d = cur - m_at;
      m_inrun  = m_active && d >= 1 && d <= 32;
      m_accept = r && s && valid_f(f) && !m_inrun && !a;
      e_stall  = m_accept || (r && m_inrun && !a);
      if (m_accept) m_f = f;
      #1;
   endtask

   task automatic tick();
      int d;
      @(posedge clk);
      if (!rst_n) m_active = 1'b0;
      else if (m_accept) begin
         m_active = 1'b1;
         m_at = cur;
      end else if (m_inrun && b32.abort) m_active = 1'b0;
      cur++;
      d = cur - m_at;
      e_ctrl = 6'h00;
      e_busy = 1'b0;
      e_done = 1'b0;
      e_step = '0;
      if (m_active && d >= 1 && d <= 32) begin
         e_ctrl = m_f;
         e_busy = 1'b1;
         e_step = 5'(d - 1);
      end else if (m_active && d == 33) begin
         e_ctrl = 6'h3F;
         e_done = 1'b1;
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 6'd27, 1'b0);
         checks++;
         if (b32.stall !== 1'b0) begin
            errs++;
            $display("FAIL reset_stall got=%b exp=0", b32.stall);
         end
         tick();
         checks++;
         if ({b32.ctrl, b32.busy, b32.done, b32.step} !== 13'h0) begin
            errs++;
            $display("FAIL reset_out got ctrl=%h busy=%b done=%b step=%0d exp all 0",
                     b32.ctrl, b32.busy, b32.done, b32.step);
         end
      end
   endtask

   task automatic test_divu();
      for (int i = 0; i < 36; i++) begin
         if (i == 0) drive(1'b1, 1'b1, 6'd27, 1'b0);
         else drive(1'b1, 1'b0, 6'd0, 1'b0);
         checks++;
         if (b32.stall !== e_stall) begin
            errs++;
            $display("FAIL divu_stall i=%0d got=%b exp=%b", i, b32.stall, e_stall);
         end
         tick();
         checks++;
         if ({b32.ctrl, b32.busy, b32.done, b32.step} !==
             {e_ctrl, e_busy, e_done, e_step}) begin
            errs++;
            $display("FAIL divu_out i=%0d got %h/%b/%b/%0d exp %h/%b/%b/%0d", i,
                     b32.ctrl, b32.busy, b32.done, b32.step,
                     e_ctrl, e_busy, e_done, e_step);
         end
      end
   endtask

   task automatic test_back_to_back();
      // second round aborts in the DONE cycle: write survives, reissue blocked
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 36; i++) begin
            if (i == 0) drive(1'b1, 1'b1, 6'd24, 1'b0);
            else if (i == 33) drive(1'b1, 1'b1, 6'd25, k == 1);
            else drive(1'b1, 1'b0, 6'd0, 1'b0);
            if (i == 33) begin
               checks++;
               if (b32.done !== 1'b1) begin
                  errs++;
                  $display("FAIL b2b_done k=%0d got=%b exp=1", k, b32.done);
               end
            end
            checks++;
            if (b32.stall !== e_stall) begin
               errs++;
               $display("FAIL b2b_stall k=%0d i=%0d got=%b exp=%b", k, i,
                        b32.stall, e_stall);
            end
            tick();
            checks++;
            if ({b32.ctrl, b32.busy, b32.done, b32.step} !==
                {e_ctrl, e_busy, e_done, e_step}) begin
               errs++;
               $display("FAIL b2b_out k=%0d i=%0d got %h/%b/%b/%0d exp %h/%b/%b/%0d",
                        k, i, b32.ctrl, b32.busy, b32.done, b32.step,
                        e_ctrl, e_busy, e_done, e_step);
            end
         end
         for (int i = 0; i < 34; i++) begin
            drive(1'b1, 1'b0, 6'd0, 1'b0);
            tick();
            checks++;
            if ({b32.ctrl, b32.done, b32.step} !== {e_ctrl, e_done, e_step}) begin
               errs++;
               $display("FAIL b2b_tail k=%0d i=%0d got %h/%b/%0d exp %h/%b/%0d",
                        k, i, b32.ctrl, b32.done, b32.step, e_ctrl, e_done, e_step);
            end
         end
      end
   endtask

   task automatic test_abort();
      int dones = 0;
      for (int i = 0; i < 52; i++) begin
         if (i == 0) drive(1'b1, 1'b1, 6'd26, 1'b0);
         else if (i == 11) drive(1'b1, 1'b0, 6'd0, 1'b1);
         else drive(1'b1, 1'b0, 6'd0, 1'b0);
         if (i == 11) begin
            checks++;
            if (b32.step !== 5'd10) begin
               errs++;
               $display("FAIL abort_step got=%0d exp=10", b32.step);
            end
         end
         checks++;
         if (b32.stall !== e_stall) begin
            errs++;
            $display("FAIL abort_stall i=%0d got=%b exp=%b", i, b32.stall, e_stall);
         end
         tick();
         if (i > 11 && b32.done === 1'b1) dones++;
         checks++;
         if ({b32.ctrl, b32.busy, b32.done, b32.step} !==
             {e_ctrl, e_busy, e_done, e_step}) begin
            errs++;
            $display("FAIL abort_out i=%0d got %h/%b/%b/%0d exp %h/%b/%b/%0d", i,
                     b32.ctrl, b32.busy, b32.done, b32.step,
                     e_ctrl, e_busy, e_done, e_step);
         end
      end
      checks++;
      if (dones !== 0) begin
         errs++;
         $display("FAIL abort_nodone got=%0d exp=0", dones);
      end
   endtask

   task automatic test_invalid();
      for (int i = 0; i < 38; i++) begin
         if (i == 0) drive(1'b1, 1'b1, 6'd32, 1'b0);
         else if (i == 1) drive(1'b1, 1'b1, 6'd27, 1'b0);
         else if (i >= 3 && i <= 6) drive(1'b1, 1'b1, 6'd24, 1'b0);
         else if (i == 8) drive(1'b1, 1'b1, 6'd40, 1'b0);
         else drive(1'b1, 1'b0, 6'd0, 1'b0);
         checks++;
         if (b32.stall !== e_stall) begin
            errs++;
            $display("FAIL inv_stall i=%0d got=%b exp=%b", i, b32.stall, e_stall);
         end
         tick();
         checks++;
         if ({b32.ctrl, b32.busy, b32.done, b32.step} !==
             {e_ctrl, e_busy, e_done, e_step}) begin
            errs++;
            $display("FAIL inv_out i=%0d got %h/%b/%b/%0d exp %h/%b/%b/%0d", i,
                     b32.ctrl, b32.busy, b32.done, b32.step,
                     e_ctrl, e_busy, e_done, e_step);
         end
      end
   endtask

   task automatic test_reset_midrun();
      int dones = 0;
      for (int i = 0; i < 45; i++) begin
         if (i == 0) drive(1'b1, 1'b1, 6'd25, 1'b0);
         else if (i == 6) drive(1'b0, 1'b0, 6'd0, 1'b0);
         else drive(1'b1, 1'b0, 6'd0, 1'b0);
         tick();
         if (b32.done === 1'b1) dones++;
         checks++;
         if ({b32.ctrl, b32.busy, b32.step} !== {e_ctrl, e_busy, e_step}) begin
            errs++;
            $display("FAIL rstrun_out i=%0d got %h/%b/%0d exp %h/%b/%0d", i,
                     b32.ctrl, b32.busy, b32.step, e_ctrl, e_busy, e_step);
         end
      end
      checks++;
      if (dones !== 0) begin
         errs++;
         $display("FAIL rstrun_nodone got=%0d exp=0", dones);
      end
   endtask

   task automatic test_random();
      logic [5:0] pool [6];
      pool = '{6'd24, 6'd25, 6'd26, 6'd27, 6'd32, 6'd0};
      for (int i = 0; i < 1500; i++) begin
         drive($urandom_range(0, 199) != 0,
               $urandom_range(0, 3) != 0,
               pool[$urandom_range(0, 5)],
               $urandom_range(0, 39) == 0);
         checks++;
         if (b32.stall !== e_stall) begin
            errs++;
            $display("FAIL rnd_stall i=%0d got=%b exp=%b", i, b32.stall, e_stall);
         end
         tick();
         checks++;
         if ({b32.ctrl, b32.busy, b32.done, b32.step} !==
             {e_ctrl, e_busy, e_done, e_step}) begin
            errs++;
            $display("FAIL rnd_out i=%0d got %h/%b/%b/%0d exp %h/%b/%b/%0d", i,
                     b32.ctrl, b32.busy, b32.done, b32.step,
                     e_ctrl, e_busy, e_done, e_step);
         end
      end
   endtask

   task automatic test_sweep();
      int bsy2 = 0, dn2 = 0, mx2 = 0, pos2 = -1, bad2 = 0;
      int bsy64 = 0, dn64 = 0, mx64 = 0, pos64 = -1, bad64 = 0;
      @(negedge clk);
      rst_n        = 1'b1;
      b2.start     = 1'b1;
      b2.op_funct  = 6'd27;
      b64.start    = 1'b1;
      b64.op_funct = 6'd25;
      #1;
      checks++;
      if ({b2.stall, b64.stall} !== 2'b11) begin
         errs++;
         $display("FAIL sweep_stall got=%b%b exp=11", b2.stall, b64.stall);
      end
      for (int i = 1; i <= 70; i++) begin
         @(posedge clk);
         cur++;
         #1;
         if (i == 1) begin
            b2.start  = 1'b0;
            b64.start = 1'b0;
         end
         if (b2.busy) begin
            bsy2++;
            if (int'(b2.step) > mx2) mx2 = int'(b2.step);
         end else if (b2.step != 0) bad2++;
         if (b2.done) begin
            dn2++;
            pos2 = i;
         end
         if (b64.busy) begin
            bsy64++;
            if (int'(b64.step) > mx64) mx64 = int'(b64.step);
         end else if (b64.step != 0) bad64++;
         if (b64.done) begin
            dn64++;
            pos64 = i;
         end
      end
      checks++;
      if (bsy2 !== 2 || dn2 !== 1 || pos2 !== 3 || mx2 !== 1 || bad2 !== 0) begin
         errs++;
         $display("FAIL sweep2 got busy=%0d done=%0d at=%0d max=%0d bad=%0d exp 2/1/3/1/0",
                  bsy2, dn2, pos2, mx2, bad2);
      end
      checks++;
      if (bsy64 !== 64 || dn64 !== 1 || pos64 !== 65 || mx64 !== 63 || bad64 !== 0) begin
         errs++;
         $display("FAIL sweep64 got busy=%0d done=%0d at=%0d max=%0d bad=%0d exp 64/1/65/63/0",
                  bsy64, dn64, pos64, mx64, bad64);
      end
   endtask

   initial begin
      b32.start    = 1'b0;
      b32.op_funct = '0;
      b32.abort    = 1'b0;
      b2.start     = 1'b0;
      b2.op_funct  = '0;
      b2.abort     = 1'b0;
      b64.start    = 1'b0;
      b64.op_funct = '0;
      b64.abort    = 1'b0;
      test_reset();
      test_divu();
      test_back_to_back();
      test_abort();
      test_invalid();
      test_reset_midrun();
      test_random();
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
